// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared types and constants for the 16-bit 5-stage pipeline control path.
//   - ctrl_state_t : sequencer states (RUN, MEM_WAIT, ERROR)
//   - REG_ADDR_W   : register-file address width
//   - pipe_ctrl_t  : bundle of PC / pipeline-register enables and flushes
//   - CTRL_BUBBLE  : all-zero control word. A flushed pipeline register
//                    loads this as its control field. It is also the
//                    "everything off" drive used in reset and ERROR.
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } pipe_ctrl_t;

  // Bubble: no enables, no flushes, all control bits zero.
  localparam pipe_ctrl_t CTRL_BUBBLE = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0
  };

  // Normal flow: every stage advances, nothing is squashed.
  localparam pipe_ctrl_t CTRL_ADVANCE = '{
    pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0
  };

  // Memory freeze: the whole pipe holds while MEM/WB receives a bubble, so
  // the stalled access is not written back more than once.
  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b1
  };

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard comparator. Flags when the instruction in
//   ID reads a register that the load currently in ID/EX will write.
//   Register 0 gets no special treatment.
// Ports:
//   id_rs1, id_rs2         in  source register addresses of the ID instruction
//   id_uses_rs1/rs2        in  the corresponding operand is actually read
//   idex_mem_read          in  ID/EX instruction is a load
//   idex_write_address     in  destination register of the ID/EX instruction
//   load_use               out hazard present
// ---------------------------------------------------------------------------
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_write_address,
  output logic                  load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_uses_rs1 && (id_rs1 == idex_write_address);
  assign w_rs2_hit = id_uses_rs2 && (id_rs2 == idex_write_address);
  assign load_use  = idex_mem_read && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Resolves taken
//   branches (flush IF/ID and ID/EX), load-use hazards (one bubble), and
//   multi-cycle data-memory accesses from EX/MEM (full freeze). Declares a
//   sticky bus error if memory does not respond within MEM_TIMEOUT wait
//   cycles, and counts stall cycles (pc_en=0) with saturation.
// Parameters:
//   MEM_TIMEOUT  maximum MEM_WAIT cycles before a bus error
//   CNT_W        stall counter width
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   id_rs1/rs2, id_uses_rs1/rs2      ID instruction source operands
//   idex_mem_read, idex_write_address  load in ID/EX and its destination
//   ex_branch_taken                  branch resolved taken in EX
//   exmem_mem_read/write             memory operation in EX/MEM
//   dmem_ready                       data memory completes this cycle
//   dmem_req                         request to data memory
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en   register load enables
//   ifid_flush, idex_flush, memwb_flush          bubble-insert controls
//   bus_error                        sticky memory timeout flag
//   stall_cycles                     saturating count of pc_en=0 cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_write_address,
  input  logic                  ex_branch_taken,
  input  logic                  exmem_mem_read,
  input  logic                  exmem_mem_write,
  input  logic                  dmem_ready,
  output logic                  dmem_req,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic                  bus_error,
  output logic [CNT_W-1:0]      stall_cycles
);

  // The wait counter only has to reach MEM_TIMEOUT-1; the state leaves
  // MEM_WAIT on that value, so it never needs to wrap.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t        r_state;
  ctrl_state_t        w_next_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_bus_error;
  logic [CNT_W-1:0]   r_stall_cycles;

  pipe_ctrl_t         w_ctrl;
  logic               w_dmem_req;
  logic               w_mem_op;
  logic               w_load_use;

  // Branch / load-use / normal priority, used both in RUN and on the
  // cycle a stalled memory access completes.
  function automatic pipe_ctrl_t resolve_hazards(input logic branch_taken,
                                                 input logic load_use);
    pipe_ctrl_t c;
    c = CTRL_ADVANCE;
    if (branch_taken) begin
      // ID is squashed, so any load-use hazard there is irrelevant.
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push one bubble into ID/EX; the load keeps
      // moving so the dependent instruction can proceed next cycle.
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

  assign w_mem_op = exmem_mem_read || exmem_mem_write;

  load_use_detect u_load_use_detect (
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_uses_rs1        (id_uses_rs1),
    .id_uses_rs2        (id_uses_rs2),
    .idex_mem_read      (idex_mem_read),
    .idex_write_address (idex_write_address),
    .load_use           (w_load_use)
  );

  // Next-state and output decode
  always_comb begin
    w_next_state = r_state;
    w_ctrl       = CTRL_BUBBLE;
    w_dmem_req   = 1'b0;

    if (reset) begin
      // Outputs held off; any outstanding access is abandoned.
      w_next_state = RUN;
    end else begin
      case (r_state)
        RUN: begin
          w_dmem_req = w_mem_op;
          if (w_mem_op && !dmem_ready) begin
            w_ctrl       = CTRL_FREEZE;
            w_next_state = MEM_WAIT;
          end else begin
            w_ctrl = resolve_hazards(ex_branch_taken, w_load_use);
          end
        end

        MEM_WAIT: begin
          w_dmem_req = 1'b1;
          if (dmem_ready) begin
            w_ctrl       = resolve_hazards(ex_branch_taken, w_load_use);
            w_next_state = RUN;
          end else begin
            w_ctrl = CTRL_FREEZE;
            if (r_wait_cnt == WAIT_LAST) begin
              w_next_state = ERROR;
            end
          end
        end

        ERROR: begin
          w_ctrl = CTRL_BUBBLE;
        end

        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

  // State, wait counter, error flag and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_bus_error    <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next_state;

      // Held at zero outside MEM_WAIT, so every entry starts counting at 0.
      if (r_state == MEM_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_next_state == ERROR) begin
        r_bus_error <= 1'b1;
      end

      if (!w_ctrl.pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign dmem_req     = w_dmem_req;
  assign pc_en        = w_ctrl.pc_en;
  assign ifid_en      = w_ctrl.ifid_en;
  assign idex_en      = w_ctrl.idex_en;
  assign exmem_en     = w_ctrl.exmem_en;
  assign memwb_en     = w_ctrl.memwb_en;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idex_flush   = w_ctrl.idex_flush;
  assign memwb_flush  = w_ctrl.memwb_flush;
  assign bus_error    = r_bus_error;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and a 3-bit
//   stall counter so saturation is reachable in a short run.
//   Control vector layout used in checks:
//   {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//    ifid_flush, idex_flush, memwb_flush, dmem_req}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 3;

  localparam logic [8:0] V_OFF     = 9'b00000_000_0;
  localparam logic [8:0] V_ADV     = 9'b11111_000_0;
  localparam logic [8:0] V_ADV_REQ = 9'b11111_000_1;
  localparam logic [8:0] V_LU      = 9'b00111_010_0;
  localparam logic [8:0] V_BR      = 9'b11111_110_0;
  localparam logic [8:0] V_BR_REQ  = 9'b11111_110_1;
  localparam logic [8:0] V_FRZ_REQ = 9'b00000_001_1;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       id_rs1, id_rs2, idex_write_address;
  logic             id_uses_rs1, id_uses_rs2, idex_mem_read;
  logic             ex_branch_taken, exmem_mem_read, exmem_mem_write, dmem_ready;
  logic             dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, memwb_flush, bus_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [8:0]       obs_ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_uses_rs1        (id_uses_rs1),
    .id_uses_rs2        (id_uses_rs2),
    .idex_mem_read      (idex_mem_read),
    .idex_write_address (idex_write_address),
    .ex_branch_taken    (ex_branch_taken),
    .exmem_mem_read     (exmem_mem_read),
    .exmem_mem_write    (exmem_mem_write),
    .dmem_ready         (dmem_ready),
    .dmem_req           (dmem_req),
    .pc_en              (pc_en),
    .ifid_en            (ifid_en),
    .idex_en            (idex_en),
    .exmem_en           (exmem_en),
    .memwb_en           (memwb_en),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .memwb_flush        (memwb_flush),
    .bus_error          (bus_error),
    .stall_cycles       (stall_cycles)
  );

  assign obs_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, memwb_flush, dmem_req};

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 4'h0; id_rs2 = 4'h0; idex_write_address = 4'h0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; exmem_mem_read = 1'b0; exmem_mem_write = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset with busy inputs: everything off
    idle_inputs();
    exmem_mem_read = 1'b1; ex_branch_taken = 1'b1;
    reset = 1'b1;
    settle();
    check("reset_ctrl_comb", 32'(obs_ctrl), 32'(V_OFF));
    cyc();
    check("reset_ctrl", 32'(obs_ctrl), 32'(V_OFF));
    check("reset_bus_error", 32'(bus_error), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    reset = 1'b0;
    idle_inputs();
    settle();
    check("idle_adv", 32'(obs_ctrl), 32'(V_ADV));

    // ---- load-use on rs1
    idex_mem_read = 1'b1; idex_write_address = 4'h3;
    id_rs1 = 4'h3; id_uses_rs1 = 1'b1;
    settle();
    check("lu_rs1", 32'(obs_ctrl), 32'(V_LU));
    cyc();
    idex_mem_read = 1'b0;          // load has moved on to EX/MEM
    settle();
    check("lu_release", 32'(obs_ctrl), 32'(V_ADV));
    check("lu_stall1", 32'(stall_cycles), 32'd1);

    // ---- matching but unused operand: no hazard
    idex_mem_read = 1'b1; id_uses_rs1 = 1'b0;
    settle();
    check("lu_unused_rs1", 32'(obs_ctrl), 32'(V_ADV));
    // ---- non-load producer: no hazard
    idex_mem_read = 1'b0; id_uses_rs1 = 1'b1;
    settle();
    check("lu_not_load", 32'(obs_ctrl), 32'(V_ADV));

    // ---- load-use on rs2 through register 0
    cyc();
    idle_inputs();
    idex_mem_read = 1'b1; idex_write_address = 4'h0;
    id_rs1 = 4'h5; id_uses_rs1 = 1'b1; id_rs2 = 4'h0; id_uses_rs2 = 1'b1;
    settle();
    check("lu_rs2_r0", 32'(obs_ctrl), 32'(V_LU));
    cyc();
    idle_inputs();
    settle();
    check("lu_stall2", 32'(stall_cycles), 32'd2);

    // ---- branch beats load-use
    idex_mem_read = 1'b1; idex_write_address = 4'h3;
    id_rs1 = 4'h3; id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1;
    settle();
    check("branch_over_lu", 32'(obs_ctrl), 32'(V_BR));
    cyc();
    idle_inputs();
    settle();
    check("branch_no_stall", 32'(stall_cycles), 32'd2);

    // ---- zero-wait store
    exmem_mem_write = 1'b1; dmem_ready = 1'b1;
    settle();
    check("zero_wait", 32'(obs_ctrl), 32'(V_ADV_REQ));
    cyc();
    idle_inputs();
    settle();
    check("zero_wait_run", 32'(obs_ctrl), 32'(V_ADV));
    check("zero_wait_stall", 32'(stall_cycles), 32'd2);

    // ---- 3-cycle load
    cyc();
    apply_reset();
    exmem_mem_read = 1'b1; dmem_ready = 1'b0;
    settle();
    check("ld3_c1", 32'(obs_ctrl), 32'(V_FRZ_REQ));
    cyc();
    check("ld3_c2", 32'(obs_ctrl), 32'(V_FRZ_REQ));
    cyc();
    dmem_ready = 1'b1;
    settle();
    check("ld3_c3", 32'(obs_ctrl), 32'(V_ADV_REQ));
    cyc();
    idle_inputs();
    settle();
    check("ld3_after", 32'(obs_ctrl), 32'(V_ADV));
    check("ld3_stall", 32'(stall_cycles), 32'd2);

    // ---- memory completion coinciding with a taken branch
    exmem_mem_read = 1'b1;
    settle();
    check("mw_br_c1", 32'(obs_ctrl), 32'(V_FRZ_REQ));
    cyc();
    dmem_ready = 1'b1; ex_branch_taken = 1'b1;
    settle();
    check("mw_br_release", 32'(obs_ctrl), 32'(V_BR_REQ));
    cyc();
    idle_inputs();
    settle();
    check("mw_br_stall", 32'(stall_cycles), 32'd3);

    // ---- timeout into ERROR, counter saturation, reset recovery
    cyc();
    apply_reset();
    exmem_mem_read = 1'b1;
    settle();
    check("to_run_freeze", 32'(obs_ctrl), 32'(V_FRZ_REQ));
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("to_wait%0d", i), 32'(obs_ctrl), 32'(V_FRZ_REQ));
      check($sformatf("to_wait%0d_err", i), 32'(bus_error), 32'd0);
    end
    cyc();
    check("to_error_ctrl", 32'(obs_ctrl), 32'(V_OFF));
    check("to_error_flag", 32'(bus_error), 32'd1);
    check("to_error_stall5", 32'(stall_cycles), 32'd5);
    dmem_ready = 1'b1;             // late response must not leave ERROR
    cyc();
    check("to_stall6", 32'(stall_cycles), 32'd6);
    cyc();
    check("to_stall7", 32'(stall_cycles), 32'd7);
    cyc();
    cyc();
    check("to_stall_sat", 32'(stall_cycles), 32'd7);
    check("to_sticky_ctrl", 32'(obs_ctrl), 32'(V_OFF));
    check("to_sticky_flag", 32'(bus_error), 32'd1);
    idle_inputs();
    apply_reset();
    settle();
    check("to_recover_ctrl", 32'(obs_ctrl), 32'(V_ADV));
    check("to_recover_flag", 32'(bus_error), 32'd0);
    check("to_recover_stall", 32'(stall_cycles), 32'd0);

    // ---- reset in the 2nd MEM_WAIT cycle
    exmem_mem_read = 1'b1;
    settle();
    check("rmw_run", 32'(obs_ctrl), 32'(V_FRZ_REQ));
    cyc();
    check("rmw_wait1", 32'(obs_ctrl), 32'(V_FRZ_REQ));
    cyc();
    check("rmw_wait2_stall", 32'(stall_cycles), 32'd2);
    reset = 1'b1;
    exmem_mem_read = 1'b0;
    settle();
    check("rmw_reset_ctrl", 32'(obs_ctrl), 32'(V_OFF));
    cyc();
    reset = 1'b0;
    settle();
    check("rmw_after_ctrl", 32'(obs_ctrl), 32'(V_ADV));
    check("rmw_after_stall", 32'(stall_cycles), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
